pattern_detector: RTL and testbench



---
 rtl/pattern_detector.sv | 61 ++++++
 tb/tb_pattern_detector.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector: shifts a sampled bit stream into a history register and
// flags when the most recent PATTERN_WIDTH samples equal PATTERN (Moore or Mealy output).
module pattern_detector #(
    parameter int                       PATTERN_WIDTH = 4,
    parameter logic [PATTERN_WIDTH-1:0] PATTERN       = 4'b1101,
    parameter int                       MEALY         = 0,
    parameter int                       OVERLAP       = 1,
    parameter int                       COUNT_WIDTH   = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 a,
    input  logic                                 clear_count,
    output logic                                 y,
    output logic [COUNT_WIDTH-1:0]               match_count,
    output logic [$clog2(PATTERN_WIDTH+1)-1:0]   fill
);

    localparam int            FW       = $clog2(PATTERN_WIDTH + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(PATTERN_WIDTH);
    localparam logic [FW-1:0] FILL_ARM = FW'(PATTERN_WIDTH - 1);

    logic [PATTERN_WIDTH-1:0] hist;
    logic [PATTERN_WIDTH-1:0] hist_next;
    logic [FW-1:0]            fill_inc;
    logic                     armed;
    logic                     hit;
    logic                     y_reg;

    assign hist_next = {hist[PATTERN_WIDTH-2:0], a};
    // Only the newest sample is outside the history, so PATTERN_WIDTH-1 held samples suffice.
    assign armed     = (fill >= FILL_ARM);
    assign hit       = armed && (hist_next == PATTERN);
    assign fill_inc  = (fill == FILL_MAX) ? FILL_MAX : fill + FW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            hist  <= '0;
            fill  <= '0;
            y_reg <= 1'b0;
        end else if (enable) begin
            hist  <= hist_next;
            fill  <= (hit && (OVERLAP == 0)) ? '0 : fill_inc;
            y_reg <= hit;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            match_count <= '0;
        end else if (clear_count) begin
            match_count <= '0;
        end else if (enable && hit && (match_count != '1)) begin
            match_count <= match_count + COUNT_WIDTH'(1);
        end
    end

    assign y = (MEALY != 0) ? hit : y_reg;

endmodule

// File: tb/tb_pattern_detector.sv
// Bench for pattern_detector: five configurations share one stimulus stream; a driver pushes
// the expected outputs of a sample-history model per cycle, a monitor pops and compares them.
module tb_pattern_detector;

    localparam int N  = 5;
    localparam int EW = 13;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic a = 1'b0;
    logic clear_count = 1'b0;

    always #5 clock = ~clock;

    logic       y0, y1, y2, y3, y4;
    logic [7:0] mc0, mc1, mc2;
    logic [1:0] mc3;
    logic [3:0] mc4;
    logic [2:0] f0, f1, f2, f3;
    logic [1:0] f4;

    pattern_detector #(.PATTERN_WIDTH(4), .PATTERN(4'b1101), .MEALY(0), .OVERLAP(1), .COUNT_WIDTH(8)) u0 (
        .clock(clock), .reset(reset), .enable(enable), .a(a), .clear_count(clear_count),
        .y(y0), .match_count(mc0), .fill(f0));
    pattern_detector #(.PATTERN_WIDTH(4), .PATTERN(4'b1101), .MEALY(0), .OVERLAP(0), .COUNT_WIDTH(8)) u1 (
        .clock(clock), .reset(reset), .enable(enable), .a(a), .clear_count(clear_count),
        .y(y1), .match_count(mc1), .fill(f1));
    pattern_detector #(.PATTERN_WIDTH(4), .PATTERN(4'b1101), .MEALY(1), .OVERLAP(1), .COUNT_WIDTH(8)) u2 (
        .clock(clock), .reset(reset), .enable(enable), .a(a), .clear_count(clear_count),
        .y(y2), .match_count(mc2), .fill(f2));
    pattern_detector #(.PATTERN_WIDTH(4), .PATTERN(4'b1101), .MEALY(0), .OVERLAP(1), .COUNT_WIDTH(2)) u3 (
        .clock(clock), .reset(reset), .enable(enable), .a(a), .clear_count(clear_count),
        .y(y3), .match_count(mc3), .fill(f3));
    pattern_detector #(.PATTERN_WIDTH(3), .PATTERN(3'b010), .MEALY(1), .OVERLAP(0), .COUNT_WIDTH(4)) u4 (
        .clock(clock), .reset(reset), .enable(enable), .a(a), .clear_count(clear_count),
        .y(y4), .match_count(mc4), .fill(f4));

    // Per-configuration reference parameters, in instance order.
    int pw   [N] = '{4, 4, 4, 4, 3};
    int pat  [N] = '{13, 13, 13, 13, 2};
    int mealy[N] = '{0, 0, 1, 0, 1};
    int ovl  [N] = '{1, 0, 1, 1, 0};
    int cmax [N] = '{255, 255, 255, 3, 15};

    // Model: recent samples (newest in bit 0), how many are valid, Moore flag, match tally.
    int hv[N];
    int hn[N];
    int ym[N];
    int mcnt[N];

    logic [N*EW-1:0] exp_q[$];
    bit   checking = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic av, input logic c);
        logic [N*EW-1:0] ent;
        int cand, hit, yexp;
        @(posedge clock);
        #1;
        reset = r;
        enable = e;
        a = av;
        clear_count = c;
        ent = '0;
        for (int i = 0; i < N; i++) begin
            cand = ((hv[i] << 1) | int'(av)) & ((1 << pw[i]) - 1);
            hit  = (hn[i] >= pw[i] - 1 && cand == pat[i]) ? 1 : 0;
            yexp = (mealy[i] != 0) ? hit : ym[i];
            ent[i*EW +: EW] = {yexp[0], 8'(mcnt[i]), 4'(hn[i])};
            if (r) begin
                hv[i] = 0; hn[i] = 0; ym[i] = 0; mcnt[i] = 0;
            end else begin
                if (c) mcnt[i] = 0;
                else if (e && hit != 0 && mcnt[i] < cmax[i]) mcnt[i]++;
                if (e) begin
                    ym[i] = hit;
                    hv[i] = cand;
                    if (hit != 0 && ovl[i] == 0) hn[i] = 0;
                    else if (hn[i] < pw[i]) hn[i]++;
                end
            end
        end
        if (checking) exp_q.push_back(ent);
    endtask

    task automatic steps(input logic [7:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) cycle(1'b0, 1'b1, bits[k], 1'b0);
    endtask

    // Monitor: every cycle is an output cycle, sampled mid-period.
    initial begin
        logic [N*EW-1:0] ent;
        logic [N*EW-1:0] act;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                ent = exp_q.pop_front();
                act = '0;
                act[0*EW +: EW] = {y0, mc0, 1'b0, f0};
                act[1*EW +: EW] = {y1, mc1, 1'b0, f1};
                act[2*EW +: EW] = {y2, mc2, 1'b0, f2};
                act[3*EW +: EW] = {y3, 6'd0, mc3, 1'b0, f3};
                act[4*EW +: EW] = {y4, 4'd0, mc4, 2'd0, f4};
                for (int i = 0; i < N; i++) begin
                    check($sformatf("y[%0d]", i), int'(act[i*EW+12]), int'(ent[i*EW+12]));
                    check($sformatf("count[%0d]", i), int'(act[i*EW+4 +: 8]), int'(ent[i*EW+4 +: 8]));
                    check($sformatf("fill[%0d]", i), int'(act[i*EW +: 4]), int'(ent[i*EW +: 4]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            hv[i] = 0; hn[i] = 0; ym[i] = 0; mcnt[i] = 0;
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checking = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Basic match, hold across idle cycles, then drop on the next step.
        steps(8'b1101, 4);
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, k[0], 1'b0);
        steps(8'b0, 1);

        // Overlapping versus discarding stream.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        steps(8'b1101101, 7);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Data toggling while disabled must not move state.
        for (int k = 0; k < 50; k++) cycle(1'b0, 1'b0, k[0], 1'b0);

        // Combinational response while disabled, then a committing step.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        steps(8'b110, 3);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        steps(8'b1, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation of the narrow counter, then clear against a matching step.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) steps(8'b1101, 4);
        steps(8'b110, 3);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-stream discards partial progress.
        steps(8'b110, 3);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        steps(8'b1, 1);
        steps(8'b101, 3);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) == 0));
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        @(posedge clock);
        @(negedge clock);
        @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
